// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit seven-segment display controller.
package seg7_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,  // nothing loaded since reset
        ST_HOLD = 2'd1,  // value just accepted, minimum hold time running
        ST_SHOW = 2'd2   // value displayed, ready for the next one
    } state_e;

    // Blink phase: ON means digits may be lit, OFF forces them dark.
    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } phase_e;

    // Blank pair packed as {hi, lo}; all ones means both digits dark.
    localparam logic [1:0] BLANK_ALL = 2'b11;

    // Opposite blink phase.
    function automatic phase_e phase_flip(input phase_e p);
        return (p == PHASE_ON) ? PHASE_OFF : PHASE_ON;
    endfunction

endpackage

// File: rtl/seg7_blink_timer.sv
// Blink half-period counter with a phase flop. Clear wins over run and
// restarts the period in the visible phase.
module seg7_blink_timer
    import seg7_pkg::*;
#(
    parameter int unsigned BLINK_HALF = 6250000,
    parameter int unsigned CNT_W      = 23
) (
    input  logic   i_Clk,
    input  logic   i_Reset,
    input  logic   i_Clear,
    input  logic   i_Run,
    output phase_e o_Phase
);

    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    logic [CNT_W-1:0] cnt_q;
    phase_e           phase_q;

    // Count 0..BLINK_HALF-1 while running, toggling the phase on each wrap.
    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Clear) begin
            cnt_q   <= '0;
            phase_q <= PHASE_ON;
        end else if (i_Run) begin
            if (cnt_q == BLINK_LAST) begin
                cnt_q   <= '0;
                phase_q <= phase_flip(phase_q);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_Phase = phase_q;

endmodule

// File: rtl/seg7_display_ctrl.sv
// Two-digit seven-segment sequencing controller: byte handshake with a
// minimum hold time, nibble outputs to the external decoders, and blank
// strobes delayed to line up with the decoders' output register.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2500000,
    parameter int unsigned BLINK_HALF  = 6250000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Valid,
    input  logic [7:0] i_Byte,
    output logic       o_Ready,
    input  logic       i_Enable,
    input  logic       i_Blink,
    input  logic       i_LZB,
    output logic [3:0] o_Nibble_Hi,
    output logic [3:0] o_Nibble_Lo,
    output logic       o_Blank_Hi,
    output logic       o_Blank_Lo
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > BLINK_HALF) ? HOLD_CYCLES : BLINK_HALF;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q;
    logic             ready_q;
    logic [3:0]       nib_hi_q;
    logic [3:0]       nib_lo_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic             enable_q;
    logic             lzb_q;
    logic [1:0]       blank_q;
    logic [1:0]       blank_d;
    logic             blank_lo_d;
    logic             accept;
    phase_e           phase;

    assign accept = i_Valid & ready_q;

    // Handshake FSM: capture on accept, hold for HOLD_CYCLES, then show.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q    <= ST_OFF;
            ready_q    <= 1'b1;
            nib_hi_q   <= 4'h0;
            nib_lo_q   <= 4'h0;
            hold_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_OFF, ST_SHOW: begin
                    if (accept) begin
                        state_q    <= ST_HOLD;
                        ready_q    <= 1'b0;
                        nib_hi_q   <= i_Byte[7:4];
                        nib_lo_q   <= i_Byte[3:0];
                        hold_cnt_q <= '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q <= ST_SHOW;
                        ready_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_OFF;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // An accept restarts the blink period so a new value is seen lit first.
    seg7_blink_timer #(
        .BLINK_HALF (BLINK_HALF),
        .CNT_W      (CNT_W)
    ) u_blink (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Clear (accept | ~i_Blink),
        .i_Run   (state_q != ST_OFF),
        .o_Phase (phase)
    );

    // Blank equations from registered state and registered display controls.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        blank_lo_d = 1'b1;
        blank_d    = BLANK_ALL;
        blank_lo_d = (state_q == ST_OFF) | ~enable_q | (phase == PHASE_OFF);
        blank_d    = {blank_lo_d | (lzb_q & (nib_hi_q == 4'h0)), blank_lo_d};
    end

    // Register controls and blanks; the blank register matches decoder latency.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            enable_q <= 1'b0;
            lzb_q    <= 1'b0;
            blank_q  <= BLANK_ALL;
        end else begin
            enable_q <= i_Enable;
            lzb_q    <= i_LZB;
            blank_q  <= blank_d;
        end
    end

    assign o_Ready     = ready_q;
    assign o_Nibble_Hi = nib_hi_q;
    assign o_Nibble_Lo = nib_lo_q;
    assign o_Blank_Hi  = blank_q[1];
    assign o_Blank_Lo  = blank_q[0];

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Randomized bench for seg7_display_ctrl. The reference model works from
// event timestamps (last accept, last blink restart) and input histories.
module tb_seg7_display_ctrl;

    localparam int HOLD  = 4;
    localparam int BLINK = 3;
    localparam int N     = 1500;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Valid = 1'b0;
    logic [7:0] i_Byte = 8'h00;
    logic       o_Ready;
    logic       i_Enable = 1'b1;
    logic       i_Blink = 1'b0;
    logic       i_LZB = 1'b0;
    logic [3:0] o_Nibble_Hi;
    logic [3:0] o_Nibble_Lo;
    logic       o_Blank_Hi;
    logic       o_Blank_Lo;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_display_ctrl #(
        .HOLD_CYCLES (HOLD),
        .BLINK_HALF  (BLINK)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .i_Valid     (i_Valid),
        .i_Byte      (i_Byte),
        .o_Ready     (o_Ready),
        .i_Enable    (i_Enable),
        .i_Blink     (i_Blink),
        .i_LZB       (i_LZB),
        .o_Nibble_Hi (o_Nibble_Hi),
        .o_Nibble_Lo (o_Nibble_Lo),
        .o_Blank_Hi  (o_Blank_Hi),
        .o_Blank_Lo  (o_Blank_Lo)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Inputs as presented during each cycle (sampled at that cycle's closing edge).
    bit       in_rst   [N];
    bit       in_en    [N];
    bit       in_lzb   [N];
    // Model view of each cycle: loaded flag, displayed byte, blink phase visible.
    bit       m_loaded [N];
    logic [7:0] m_byte [N];
    bit       m_lit    [N];

    function automatic logic [7:0] gen_byte();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return {4'h0, 4'($urandom_range(0, 15))};
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int  last_acc;
        int  clr_s;
        bit  m_ready;
        bit  acc;
        bit  rst;
        bit  cur_valid;
        bit  cur_en;
        bit  cur_blink;
        bit  cur_lzb;
        logic [7:0] cur_byte;
        bit  exp_lo;
        bit  exp_hi;

        last_acc    = 0;
        clr_s       = 0;
        cur_valid   = 1'b0;
        cur_en      = 1'b1;
        cur_blink   = 1'b0;
        cur_lzb     = 1'b0;
        cur_byte    = 8'h00;
        m_loaded[0] = 1'b0;
        m_byte[0]   = 8'h00;

        for (int t = 0; t < N; t++) begin
            @(negedge i_Clk);

            // Expected outputs for this cycle.
            m_ready  = !m_loaded[t] || ((t - last_acc) > HOLD);
            m_lit[t] = !m_loaded[t] || ((((t - clr_s - 1) / BLINK) % 2) == 0);

            if (t >= 1) begin
                if (in_rst[t-1]) begin
                    exp_lo = 1'b1;
                    exp_hi = 1'b1;
                end else begin
                    exp_lo = !m_loaded[t-1] || !in_en[t-2] || !m_lit[t-1];
                    exp_hi = exp_lo || (in_lzb[t-2] && (m_byte[t-1][7:4] == 4'h0));
                end
                check("ready",   32'(o_Ready),     32'(m_ready));
                check("nib_hi",  32'(o_Nibble_Hi), 32'(m_byte[t][7:4]));
                check("nib_lo",  32'(o_Nibble_Lo), 32'(m_byte[t][3:0]));
                check("blank_hi", 32'(o_Blank_Hi), 32'(exp_hi));
                check("blank_lo", 32'(o_Blank_Lo), 32'(exp_lo));
            end

            // Random stimulus with slowly changing display controls.
            rst = (t == 0) || ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) cur_blink = !cur_blink;
            if (cur_en ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 7) == 0))
                cur_en = !cur_en;
            if ($urandom_range(0, 14) == 0) cur_lzb = !cur_lzb;
            if (!cur_valid && ($urandom_range(0, 2) == 0)) begin
                cur_valid = 1'b1;
                cur_byte  = gen_byte();
            end

            i_Reset  = rst;
            i_Valid  = cur_valid;
            i_Byte   = cur_byte;
            i_Enable = cur_en;
            i_Blink  = cur_blink;
            i_LZB    = cur_lzb;

            in_rst[t] = rst;
            in_en[t]  = cur_en;
            in_lzb[t] = cur_lzb;

            // Advance the model across the closing edge of this cycle.
            acc = cur_valid && m_ready && !rst;
            if (rst) begin
                clr_s = t;
            end else if (acc) begin
                last_acc = t;
                clr_s    = t;
            end else if (!cur_blink) begin
                clr_s = t;
            end
            if (t + 1 < N) begin
                m_loaded[t+1] = rst ? 1'b0 : (acc ? 1'b1 : m_loaded[t]);
                m_byte[t+1]   = rst ? 8'h00 : (acc ? cur_byte : m_byte[t]);
            end

            // Producer: after a transfer either stays busy with a new byte or idles.
            if (acc) begin
                if ($urandom_range(0, 1) == 0) cur_byte = gen_byte();
                else cur_valid = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
Sequencing controller for the board's two-digit seven-segment display. Accepts a byte from a producer over a valid/ready handshake and enforces a minimum readable hold time per value. Drives the high and low nibble into two instances of the existing registered nibble-to-7SD decoder, and generates per-digit blank strobes for blink and leading-zero suppression. The top level gates the decoder segment outputs with these blank strobes.

Parameters:
HOLD_CYCLES, 2500000, minimum cycles a newly accepted value is shown before the next is accepted (100 ms at 25 MHz); legal range >= 1
BLINK_HALF, 6250000, cycles per blink half-period (250 ms at 25 MHz); legal range >= 1
CNT_W, $clog2(max(HOLD_CYCLES,BLINK_HALF)+1), counter width; derived, do not override

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_Valid  in  1  producer has a byte on i_Byte
i_Byte  in  8  value to display; [7:4] goes to the high digit, [3:0] to the low digit
o_Ready  out  1  controller accepts i_Byte this cycle
i_Enable  in  1  display enable; 0 blanks both digits, handshake unaffected
i_Blink  in  1  blink the displayed value
i_LZB  in  1  leading-zero blank: blank the high digit when its nibble is 0
o_Nibble_Hi  out  4  to the high-digit decoder
o_Nibble_Lo  out  4  to the low-digit decoder
o_Blank_Hi  out  1  1 = high digit dark; aligned with decoder output
o_Blank_Lo  out  1  1 = low digit dark; aligned with decoder output

Behaviour:
- One clock, i_Clk. Synchronous active-high reset i_Reset. All outputs are registered.
- Reset values:
  - state=OFF, o_Ready=1, o_Nibble_Hi/Lo=0, o_Blank_Hi/Lo=1.
  - Hold counter=0, blink counter=0, blink phase=ON.
- States:
  - OFF: nothing loaded since reset; o_Ready=1.
  - HOLD: value accepted, hold counter running; o_Ready=0.
  - SHOW: value displayed; o_Ready=1.
- Accept rule: a transfer occurs on a rising edge with i_Valid=1 and o_Ready=1.
  - i_Byte is captured, and o_Nibble_Hi/Lo show it from the next cycle.
  - state->HOLD and o_Ready=0 from the next cycle.
- If i_Valid=1 while o_Ready=0, the input is ignored and nothing is captured. The producer must hold i_Valid/i_Byte until the transfer.
- HOLD: o_Ready stays low for exactly HOLD_CYCLES cycles after the accept edge, then state->SHOW and o_Ready=1.
  - SHOW->HOLD on the next accept.
  - Back-to-back producer: one transfer every HOLD_CYCLES+1 cycles.
- Blink timer (runs only when state!=OFF and i_Blink=1):
  - Counts 0..BLINK_HALF-1. On terminal count it toggles phase ON/OFF and wraps to 0.
  - i_Blink=0 clears the counter and forces phase ON.
  - An accept also clears the counter and forces phase ON, so a new value is always visible first.
- Blank equations, computed from registered state and delayed one extra cycle:
  - blank_lo = (state==OFF) | ~i_Enable | (phase==OFF)
  - blank_hi = blank_lo | (i_LZB & nibble_hi==0)
  - The extra cycle delay matches the decoder's one-cycle register, so blank and segments change on the same edge.
- Value 0x00 with i_LZB=1: high digit dark, low digit shows "0". The low digit is never LZB-blanked.
- i_Enable, i_Blink and i_LZB are sampled every cycle and may change at any time. Their effect reaches o_Blank_* 2 cycles later.
- Reset mid-HOLD or mid-blink: everything returns to reset values on the next edge. Reset overrides a simultaneous accept.
- Simultaneous accept and blink terminal count: the accept wins; phase=ON and counter=0.

Decomposition:
- Package seg7_pkg holds:
  - state enum {OFF, HOLD, SHOW}
  - BLANK_ALL constant
  - blink phase encoding
- Natural sub-module: seg7_blink_timer, containing the counter plus phase flop, with clear and enable inputs and a phase output.
- The two decoder instances live in the top level, not in this block.

Test Plan:
All scenarios use HOLD_CYCLES=4, BLINK_HALF=3.
1. Reset, then idle 5 cycles -> o_Ready=1, o_Blank_Hi=o_Blank_Lo=1, nibbles 0.
2. i_Valid=1 with i_Byte=0x5A held for 12 cycles -> accepts on cycle 0 and cycle 5 only. o_Nibble_Hi=5 and o_Nibble_Lo=A from cycle 1. o_Ready low for cycles 1-4. Blanks=0 from cycle 2.
3. Accept 0x07 with i_LZB=1 -> o_Blank_Hi=1, o_Blank_Lo=0. Drop i_LZB -> o_Blank_Hi=0 two cycles later. Accept 0x00 with i_LZB=1 -> o_Blank_Hi=1, o_Blank_Lo=0.
4. i_Blink=1 while in SHOW -> both blanks toggle every 3 cycles, starting visible. An accept mid-OFF-phase forces visible 2 cycles later, and the period restarts.
5. i_Reset pulsed on the 2nd HOLD cycle -> next cycle state=OFF, o_Ready=1, blanks=1. The held value is not re-shown.
6. i_Enable=0 during blink and handshake -> both blanks stay 1, yet transfers still occur every 5 cycles. i_Enable=1 -> digits visible 2 cycles later.
